dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline register and a slow backing data memory.
- Replaces the single-cycle data memory access in the MEM stage. Hits complete in the same cycle; misses assert a pipeline stall while lines are written back and refilled over a request/acknowledge bus.

---
 rtl/dcache_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// sitting between the EX/MEM register and a slow line-wide backing memory.
// Hits complete combinationally in IDLE; a miss stalls the pipeline while the
// dirty victim (if any) is written back and the line is refilled.
// Optional build macro: DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
//
// Memory handshake: mem_req_o is held high with mem_we_o/mem_addr_o/mem_wdata_o
// stable until mem_ack_i is seen high at a clock edge; one ack completes one
// line transfer, and an ack arriving while mem_req_o is low is ignored.
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [32*WORDS-1:0]   mem_wdata_o,
    input  logic [32*WORDS-1:0]   mem_rdata_i,
    input  logic                  mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int WBITS = $clog2(WORDS);
    localparam int IBITS = $clog2(LINES);
    localparam int TBITS = 32 - IBITS - WBITS - 2;
    localparam int LW    = 32 * WORDS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBACK  = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Line storage: only valid/dirty are reset, tags and data are not.
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TBITS-1:0] tag_q  [LINES];
    logic [LW-1:0]    data_q [LINES];

    // Line address of the outstanding miss.
    logic [TBITS-1:0] miss_tag_q;
    logic [IBITS-1:0] miss_idx_q;

    // CPU address split.
    logic [WBITS-1:0] cpu_word;
    logic [IBITS-1:0] cpu_idx;
    logic [TBITS-1:0] cpu_tag;
    logic             unused_addr_bits;

    assign cpu_word         = cpu_addr_i[WBITS+1:2];
    assign cpu_idx          = cpu_addr_i[WBITS+2 +: IBITS];
    assign cpu_tag          = cpu_addr_i[31 -: TBITS];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    logic [LW-1:0] cpu_line;
    logic [LW-1:0] victim_line;
    logic          hit;
    logic          idle_hit;
    logic          idle_miss;
    logic          store_hit;
    logic          refill_done;

    assign cpu_line    = data_q[cpu_idx];
    assign victim_line = data_q[miss_idx_q];
    assign hit         = cpu_req_i && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign idle_hit    = (state_q == IDLE) && hit;
    assign idle_miss   = (state_q == IDLE) && cpu_req_i && !hit;
    assign store_hit   = idle_hit && cpu_we_i;
    assign refill_done = (state_q == REFILL) && mem_ack_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; IDLE drives every memory output to zero.
    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (hit) begin
                        if (!cpu_we_i) begin
                            cpu_rdata_o = cpu_line[{cpu_word, 5'b0} +: 32];
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WBACK : REFILL;
                    end
                end
            end
            WBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[miss_idx_q], miss_idx_q, {(WBITS+2){1'b0}}};
                mem_wdata_o = victim_line;
                if (mem_ack_i) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {miss_tag_q, miss_idx_q, {(WBITS+2){1'b0}}};
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Valid/dirty bookkeeping: stores dirty a hit line, refills install a clean line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store_hit) begin
                dirty_q[cpu_idx] <= 1'b1;
            end
            if (refill_done) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Latch the miss line address; memory traffic never looks at the live CPU address.
    always_ff @(posedge clk_i) begin
        if (idle_miss) begin
            miss_tag_q <= cpu_tag;
            miss_idx_q <= cpu_idx;
        end
    end

    // Tag/data arrays: word merge on store hits, whole-line write on refill.
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            data_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_wdata_i;
        end
        if (refill_done) begin
            data_q[miss_idx_q] <= mem_rdata_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        post_fill_q;

    // Count unstalled hits (not the hit that retires a refilled miss) and miss entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            post_fill_q <= 1'b0;
        end else begin
            post_fill_q <= refill_done;
            if (idle_hit && !post_fill_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (idle_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    // Default build: no statistics counters.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven bench for dcache_ctrl with a flat reference
// memory, a line-wide backing-memory responder and a load-data scoreboard.
module tb_dcache_ctrl;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int LW    = 32 * WORDS;

  logic          clk;
  logic          rst_i;
  logic          cpu_req_i;
  logic          cpu_we_i;
  logic [31:0]   cpu_addr_i;
  logic [31:0]   cpu_wdata_i;
  logic [31:0]   cpu_rdata_o;
  logic          cpu_stall_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i;
  logic          mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_cnt_o;
  logic [31:0]   miss_cnt_o;
`endif

  dcache_ctrl #(.LINES(LINES), .WORDS(WORDS)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int tests_run = 0;
  int fails     = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  // Initial memory contents: every word is tagged with its own address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {16'hD47A, a[15:0]};
  endfunction

  // CPU-visible view of memory: the cache must be transparent to it.
  logic [31:0] ref_words [bit [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    bit [31:0] k;
    k = {a[31:2], 2'b00};
    if (ref_words.exists(k)) return ref_words[k];
    return init_word(k);
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] la);
    return {ref_read(la + 32'd12), ref_read(la + 32'd8), ref_read(la + 32'd4), ref_read(la)};
  endfunction

  // Backing memory as seen on the line bus; only write-backs update it.
  logic [LW-1:0] mem_model [bit [31:0]];

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    bit [31:0] k;
    k = la;
    if (mem_model.exists(k)) return mem_model[k];
    return {init_word(la + 32'd12), init_word(la + 32'd8), init_word(la + 32'd4), init_word(la)};
  endfunction

  // ---------------- scoreboard queues ----------------
  logic [31:0]   exp_q[$];      // expected load data
  logic [31:0]   wb_addr_q[$];  // expected write-back addresses
  logic [LW-1:0] wb_exp_q[$];   // expected write-back lines
  logic [31:0]   rf_addr_q[$];  // expected refill addresses

  // ---------------- backing-memory responder ----------------
  // Acks in the mem_lat-th consecutive request cycle (1 = same-cycle ack).
  int mem_lat    = 1;
  int req_cycles = 0;

  initial begin
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      mem_ack_i = 1'b0;
      if (mem_req_o && !rst_i) begin
        req_cycles++;
        if (req_cycles >= mem_lat) begin
          req_cycles = 0;
          mem_ack_i  = 1'b1;
          if (mem_we_o) begin
            if (wb_addr_q.size() == 0) begin
              tests_run++;
              fails++;
              $display("FAIL unexpected_wb: got write-back to %h, want none", mem_addr_o);
            end else begin
              check32("wb_addr", mem_addr_o, wb_addr_q.pop_front());
              check_line("wb_data", mem_wdata_o, wb_exp_q.pop_front());
            end
            mem_model[mem_addr_o] = mem_wdata_o;
          end else begin
            if (rf_addr_q.size() == 0) begin
              tests_run++;
              fails++;
              $display("FAIL unexpected_refill: got refill of %h, want none", mem_addr_o);
            end else begin
              check32("refill_addr", mem_addr_o, rf_addr_q.pop_front());
            end
            mem_rdata_i = mem_line(mem_addr_o);
          end
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic        exp_wb;
    logic [31:0] wb_addr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  // Drive one CPU access, hold it through the stall and score the result.
  task automatic run_access(input vec_t v, input string name);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    mem_lat = v.lat;
    if (v.exp_stall > 0) rf_addr_q.push_back({v.addr[31:4], 4'h0});
    if (v.exp_wb) begin
      wb_addr_q.push_back(v.wb_addr);
      wb_exp_q.push_back(ref_line(v.wb_addr));
    end
    if (v.we) ref_words[{v.addr[31:2], 2'b00}] = v.wdata;
    else exp_q.push_back(ref_read(v.addr));
    cpu_req_i   = 1'b1;
    cpu_we_i    = v.we;
    cpu_addr_i  = v.addr;
    cpu_wdata_i = v.wdata;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (cpu_stall_o) begin
        stalls++;
      end else begin
        done = 1'b1;
        if (!v.we) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL %s_sb: got load data %h, want none queued", name, cpu_rdata_o);
          end else begin
            check32({name, "_rdata"}, cpu_rdata_o, exp_q.pop_front());
          end
        end
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: got stall still high after %0d cycles, want release", name, stalls);
    end
    check32({name, "_stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check32({name, "_stall"}, 32'(cpu_stall_o), 32'd0);
    check32({name, "_rdata"}, cpu_rdata_o, 32'd0);
    check32({name, "_mem_req"}, 32'(mem_req_o), 32'd0);
    check32({name, "_mem_we"}, 32'(mem_we_o), 32'd0);
    check32({name, "_mem_addr"}, mem_addr_o, 32'd0);
    check_line({name, "_mem_wdata"}, mem_wdata_o, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;

    //           we    addr            wdata           lat st  wb    wb_addr
    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,          10, 11, 1'b0, 32'h0};   // cold load miss
    vecs[1]  = '{1'b1, 32'h0000_0044, 32'h1234_5678,  1,  0,  1'b0, 32'h0};   // store hit
    vecs[2]  = '{1'b0, 32'h0000_0044, 32'h0,          1,  0,  1'b0, 32'h0};   // load hit
    vecs[3]  = '{1'b0, 32'h0000_0140, 32'h0,          3,  7,  1'b1, 32'h40};  // dirty eviction
    vecs[4]  = '{1'b1, 32'h0000_0070, 32'hCAFE_F00D,  1,  2,  1'b0, 32'h0};   // store miss, zero-wait
    vecs[5]  = '{1'b0, 32'h0000_0070, 32'h0,          1,  0,  1'b0, 32'h0};   // merged store visible
    vecs[6]  = '{1'b0, 32'h0000_0048, 32'h0,          2,  3,  1'b0, 32'h0};   // clean eviction
    vecs[7]  = '{1'b0, 32'h0000_0044, 32'h0,          1,  0,  1'b0, 32'h0};   // data back from memory
    vecs[8]  = '{1'b1, 32'h0000_0174, 32'h0BAD_BEEF,  1,  3,  1'b1, 32'h70};  // zero-wait wb + refill
    vecs[9]  = '{1'b0, 32'h0000_0070, 32'h0,          2,  5,  1'b1, 32'h170}; // ping-pong eviction
    vecs[10] = '{1'b0, 32'h0000_0174, 32'h0,          1,  2,  1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_03FC, 32'h55AA_33CC,  4,  5,  1'b0, 32'h0};   // last index, last word
    vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,          1,  0,  1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'hFFFF_FF08, 32'h0,          1,  2,  1'b0, 32'h0};   // all-ones tag

    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    @(negedge clk);
    check_idle_outputs("reset");
`ifdef DCACHE_STATS_EN
    check32("reset_hit_cnt", hit_cnt_o, 32'd0);
    check32("reset_miss_cnt", miss_cnt_o, 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_access(vecs[i], $sformatf("v%0d", i));
`ifdef DCACHE_STATS_EN
      if (i == 4) begin
        check32("stats_hit_cnt", hit_cnt_o, 32'd2);
        check32("stats_miss_cnt", miss_cnt_o, 32'd3);
      end
`endif
      @(negedge clk);
      check32($sformatf("v%0d_idle_rdata", i), cpu_rdata_o, 32'd0);
      check32($sformatf("v%0d_idle_req", i), 32'(mem_req_o), 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a refill that memory never answers.
    mem_lat     = 1000;
    cpu_req_i   = 1'b1;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0000_0200;
    cpu_wdata_i = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check32("abort_stall", 32'(cpu_stall_o), 32'd1);
    check32("abort_req", 32'(mem_req_o), 32'd1);
    check32("abort_we", 32'(mem_we_o), 32'd0);
    check32("abort_addr", mem_addr_o, 32'h0000_0200);
    @(posedge clk);
    #1;
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_outputs("mid_refill_reset");
`ifdef DCACHE_STATS_EN
    check32("rst_hit_cnt", hit_cnt_o, 32'd0);
    check32("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // The aborted address misses again; no line survives reset valid or dirty.
    v = '{1'b0, 32'h0000_0200, 32'h0, 1, 2, 1'b0, 32'h0};
    run_access(v, "post_rst_200");
    v = '{1'b0, 32'h0000_07FC, 32'h0, 1, 2, 1'b0, 32'h0};
    run_access(v, "post_rst_no_wb");
    v = '{1'b0, 32'h0000_0044, 32'h0, 1, 2, 1'b0, 32'h0};
    run_access(v, "post_rst_44");

    @(negedge clk);
    check32("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check32("wb_q_empty", 32'(wb_addr_q.size()), 32'd0);
    check32("rf_q_empty", 32'(rf_addr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
